// File: rtl/pc_md_pkg.sv
// Shared constants and the operation-select type for the PC/MD block.
package pc_md_pkg;

    localparam int PC_MD_DATA_W      = 18;
    localparam int PC_MD_ADDR_W      = 13;
    localparam int PC_MD_STACK_DEPTH = 4;

    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int SP_W = sp_width(PC_MD_STACK_DEPTH);

    // One operation wins per cycle; the decode order encodes bus priority.
    typedef enum logic [3:0] {
        OP_NONE,
        OP_READ_MD,
        OP_WRITE_MEM_MD,
        OP_WRITE_MD,
        OP_READ_PC,
        OP_WRITE_PC,
        OP_CALL,
        OP_RET,
        OP_BRANCH
    } op_e;

endpackage

// File: rtl/pc_md_ret_stack.sv
// Return-address LIFO with registered full/empty and a sticky over/underflow flag.
module pc_md_ret_stack
    import pc_md_pkg::*;
#(
    parameter int ADDR_W      = PC_MD_ADDR_W,
    parameter int STACK_DEPTH = PC_MD_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    localparam int SpW  = sp_width(STACK_DEPTH);
    localparam int IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem_q [2**IdxW];
    logic [SpW-1:0]    sp_q, sp_d;
    logic              full_q, empty_q, err_q, err_d;
    logic              do_write;
    logic [IdxW-1:0]   wr_idx, top_idx;

    assign wr_idx  = IdxW'(sp_q);
    assign top_idx = IdxW'(sp_q - SpW'(1));

    always_comb begin
        sp_d     = sp_q;
        err_d    = err_q;
        do_write = 1'b0;
        if (push_i) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                do_write = 1'b1;
                sp_d     = sp_q + SpW'(1);
            end
        end else if (pop_i) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                sp_d = sp_q - SpW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q    <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            sp_q    <= sp_d;
            err_q   <= err_d;
            full_q  <= (sp_d == SpW'(STACK_DEPTH));
            empty_q <= (sp_d == '0);
        end
    end

    // Entry contents are not reset; only the pointer defines validity.
    always_ff @(posedge clk) begin
        if (do_write && !rst) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_data_o = mem_q[top_idx];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign err_o      = err_q;

endmodule

// File: rtl/pc_md_stack.sv
// PC/MD register pair with return-address stack and optional PC-relative branch.
// Define PC_MD_BRANCH_REL_EN to enable branch_rel_en; otherwise the port is ignored.
module pc_md_stack
    import pc_md_pkg::*;
#(
    parameter int DATA_W      = PC_MD_DATA_W,
    parameter int ADDR_W      = PC_MD_ADDR_W,
    parameter int STACK_DEPTH = PC_MD_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_data_mem,
    input  logic              read_md_en,
    input  logic              write_mem_md,
    input  logic              write_md_en,
    input  logic              read_pc_en,
    input  logic              write_pc_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              branch_rel_en,
    input  logic              inc_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err
);

    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ret_addr;
    logic [DATA_W-1:0] md_q, md_d, out_q, out_d;
    logic              push, pop, branch_req;
    op_e               op;

`ifdef PC_MD_BRANCH_REL_EN
    assign branch_req = branch_rel_en;
`else
    logic unused_branch_rel;
    assign unused_branch_rel = branch_rel_en;
    assign branch_req        = 1'b0;
`endif

    always_comb begin
        op = OP_NONE;
        if      (read_md_en)   op = OP_READ_MD;
        else if (write_mem_md) op = OP_WRITE_MEM_MD;
        else if (write_md_en)  op = OP_WRITE_MD;
        else if (read_pc_en)   op = OP_READ_PC;
        else if (write_pc_en)  op = OP_WRITE_PC;
        else if (call_en)      op = OP_CALL;
        else if (ret_en)       op = OP_RET;
        else if (branch_req)   op = OP_BRANCH;
    end

    assign pc_inc = pc_q + ADDR_W'(1);

    // Increment is the default; PC-loading ops override it, even when they fault.
    always_comb begin
        pc_d  = inc_pc ? pc_inc : pc_q;
        md_d  = md_q;
        out_d = out_q;
        push  = 1'b0;
        pop   = 1'b0;
        case (op)
            OP_READ_MD:      out_d = md_q;
            OP_WRITE_MEM_MD: md_d  = in_data_mem;
            OP_WRITE_MD:     md_d  = in_data;
            OP_READ_PC:      out_d = DATA_W'(pc_q);
            OP_WRITE_PC:     pc_d  = in_data[ADDR_W-1:0];
            OP_CALL: begin
                push = 1'b1;
                pc_d = stack_full ? pc_q : in_data[ADDR_W-1:0];
            end
            OP_RET: begin
                pop  = 1'b1;
                pc_d = stack_empty ? pc_q : ret_addr;
            end
`ifdef PC_MD_BRANCH_REL_EN
            OP_BRANCH:       pc_d  = pc_q + in_data[ADDR_W-1:0];
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= '0;
            md_q  <= '0;
            out_q <= '0;
        end else begin
            pc_q  <= pc_d;
            md_q  <= md_d;
            out_q <= out_d;
        end
    end

    pc_md_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_inc),
        .top_data_o  (ret_addr),
        .full_o      (stack_full),
        .empty_o     (stack_empty),
        .err_o       (stack_err)
    );

    assign out_data = out_q;
    assign pc_addr  = pc_q;

endmodule

// File: tb/tb_pc_md_stack.sv
// Directed bench for pc_md_stack with a queue-based reference model.
module tb_pc_md_stack;

    localparam int DW    = 18;
    localparam int AW    = 13;
    localparam int DEPTH = 4;
    localparam int AMASK = (1 << AW) - 1;
`ifdef PC_MD_BRANCH_REL_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data, in_data_mem;
    logic          read_md_en, write_mem_md, write_md_en, read_pc_en;
    logic          write_pc_en, call_en, ret_en, branch_rel_en, inc_pc;
    logic [DW-1:0] out_data;
    logic [AW-1:0] pc_addr;
    logic          stack_full, stack_empty, stack_err;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference model state
    int m_pc, m_md, m_out;
    bit m_err;
    int ras[$];

    always #5 clk = ~clk;

    pc_md_stack #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_data_mem   (in_data_mem),
        .read_md_en    (read_md_en),
        .write_mem_md  (write_mem_md),
        .write_md_en   (write_md_en),
        .read_pc_en    (read_pc_en),
        .write_pc_en   (write_pc_en),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .branch_rel_en (branch_rel_en),
        .inc_pc        (inc_pc),
        .out_data      (out_data),
        .pc_addr       (pc_addr),
        .stack_full    (stack_full),
        .stack_empty   (stack_empty),
        .stack_err     (stack_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_pc_addr", int'(pc_addr), m_pc);
            chk("model_out_data", int'(out_data), m_out);
            chk("model_stack_full", int'(stack_full), int'(ras.size() == DEPTH));
            chk("model_stack_empty", int'(stack_empty), int'(ras.size() == 0));
            chk("model_stack_err", int'(stack_err), int'(m_err));
        end
    end

    task automatic model_update();
        bit loaded;
        loaded = 1'b0;
        if (rst) begin
            m_pc = 0; m_md = 0; m_out = 0; m_err = 1'b0;
            ras.delete();
        end else begin
            if (read_md_en)        m_out = m_md;
            else if (write_mem_md) m_md = int'(in_data_mem);
            else if (write_md_en)  m_md = int'(in_data);
            else if (read_pc_en)   m_out = m_pc;
            else if (write_pc_en) begin
                m_pc = int'(in_data) & AMASK; loaded = 1'b1;
            end else if (call_en) begin
                loaded = 1'b1;
                if (ras.size() < DEPTH) begin
                    ras.push_back((m_pc + 1) & AMASK);
                    m_pc = int'(in_data) & AMASK;
                end else m_err = 1'b1;
            end else if (ret_en) begin
                loaded = 1'b1;
                if (ras.size() > 0) m_pc = ras.pop_back();
                else m_err = 1'b1;
            end else if (branch_rel_en && BR_EN) begin
                loaded = 1'b1;
                m_pc = (m_pc + (int'(in_data) & AMASK)) & AMASK;
            end
            if (!loaded && inc_pc) m_pc = (m_pc + 1) & AMASK;
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; in_data = '0; in_data_mem = '0;
        read_md_en = 1'b0; write_mem_md = 1'b0; write_md_en = 1'b0; read_pc_en = 1'b0;
        write_pc_en = 1'b0; call_en = 1'b0; ret_en = 1'b0; branch_rel_en = 1'b0; inc_pc = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, then return to idle after the negedge.
    task automatic step();
        @(posedge clk);
        model_update();
        check_en = 1'b1;
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic set_pc(input int v);
        write_pc_en = 1'b1; in_data = DW'(v); step();
    endtask

    task automatic do_call(input int tgt, input bit inc);
        call_en = 1'b1; in_data = DW'(tgt); inc_pc = inc; step();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1; in_data = DW'(18'h3FFFF); call_en = 1'b1;
        step();
        rst = 1'b1; step();
        chk("reset_pc", int'(pc_addr), 0);
        chk("reset_out", int'(out_data), 0);
        chk("reset_empty", int'(stack_empty), 1);
        chk("reset_full", int'(stack_full), 0);
        chk("reset_err", int'(stack_err), 0);

        for (int i = 1; i <= 3; i++) begin
            inc_pc = 1'b1; step();
            chk("inc_pc_seq", int'(pc_addr), i);
        end
        read_pc_en = 1'b1; step();
        chk("read_pc_out", int'(out_data), 3);

        write_mem_md = 1'b1; in_data_mem = 18'h2A5A3; step();
        read_md_en = 1'b1; step();
        chk("read_md_mem", int'(out_data), 'h2A5A3);
        read_md_en = 1'b1; write_md_en = 1'b1; in_data = 18'h12345; step();
        read_md_en = 1'b1; step();
        chk("md_priority_hold", int'(out_data), 'h2A5A3);

        read_pc_en = 1'b1; write_pc_en = 1'b1; in_data = 18'h00777; inc_pc = 1'b1; step();
        chk("read_pc_beats_write_pc", int'(out_data), 3);
        chk("read_pc_inc", int'(pc_addr), 4);

        set_pc('h010);
        do_call('h100, 1'b1);
        chk("call_pc", int'(pc_addr), 'h100);
        chk("call_not_empty", int'(stack_empty), 0);
        inc_pc = 1'b1; step();
        ret_en = 1'b1; inc_pc = 1'b1; step();
        chk("ret_pc", int'(pc_addr), 'h011);
        chk("ret_empty", int'(stack_empty), 1);

        do_call('h200, 1'b0);
        do_call('h300, 1'b0);
        do_call('h400, 1'b0);
        do_call('h500, 1'b0);
        chk("four_calls_full", int'(stack_full), 1);
        chk("four_calls_no_err", int'(stack_err), 0);
        do_call('h600, 1'b1);
        chk("overflow_pc_hold", int'(pc_addr), 'h500);
        chk("overflow_err", int'(stack_err), 1);
        step();
        chk("err_sticky", int'(stack_err), 1);
        for (int i = 0; i < DEPTH; i++) begin
            ret_en = 1'b1; step();
        end
        chk("unwind_pc", int'(pc_addr), 'h012);
        ret_en = 1'b1; inc_pc = 1'b1; step();
        chk("underflow_pc_hold", int'(pc_addr), 'h012);
        chk("underflow_err", int'(stack_err), 1);

        set_pc('h005);
        branch_rel_en = 1'b1; in_data = DW'(13'h1FFD); step();
        chk("branch_rel", int'(pc_addr), BR_EN ? 'h002 : 'h005);
        set_pc('h005);
        branch_rel_en = 1'b1; in_data = DW'(13'h0010); inc_pc = 1'b1; step();
        chk("branch_rel_vs_inc", int'(pc_addr), BR_EN ? 'h015 : 'h006);
        set_pc('h1FFF);
        inc_pc = 1'b1; step();
        chk("pc_wrap", int'(pc_addr), 0);

        set_pc('h040);
        do_call('h111, 1'b0);
        rst = 1'b1; call_en = 1'b1; in_data = DW'('h100); inc_pc = 1'b1; step();
        chk("rst_call_pc", int'(pc_addr), 0);
        chk("rst_call_empty", int'(stack_empty), 1);
        chk("rst_call_err", int'(stack_err), 0);
        chk("rst_call_out", int'(out_data), 0);
        ret_en = 1'b1; step();
        chk("post_rst_underflow", int'(stack_err), 1);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
